// File: rtl/rtc_mmio.sv
// rtc_mmio: memory-mapped real-time clock with HH:MM:SS time, an alarm with
// interrupt, and a free-running seconds-since-enable uptime counter.
module rtc_mmio #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
    parameter int unsigned TICKS_PER_SEC = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        Irq
);

    localparam logic [23:0] PS_LAST = 24'(TICKS_PER_SEC - 1);

    logic [23:0] ps_q, ps_d;
    logic        en_q, en_d;
    logic        alarm_en_q, alarm_en_d;
    logic        pend_q, pend_d;
    logic [5:0]  ss_q, ss_d, mm_q, mm_d;
    logic [4:0]  hh_q, hh_d;
    logic [5:0]  al_ss_q, al_ss_d, al_mm_q, al_mm_d;
    logic [4:0]  al_hh_q, al_hh_d;
    logic [31:0] uptime_q, uptime_d;

    logic        hit;
    logic        wr_ctrl, wr_time, wr_alarm;
    logic        run, tick, match;
    logic [5:0]  wd_ss, wd_mm, nx_ss, nx_mm;
    logic [4:0]  wd_hh, nx_hh;
    logic        unused_bits;

    // Address decode, write strobes and range-clamped write fields.
    always_comb begin
        hit      = (ALUResult[31:4] == BASE_ADDR[31:4]);
        wr_ctrl  = MemWrite && hit && (ALUResult[3:2] == 2'd0);
        wr_time  = MemWrite && hit && (ALUResult[3:2] == 2'd1);
        wr_alarm = MemWrite && hit && (ALUResult[3:2] == 2'd2);
        wd_ss    = (WriteData[5:0]   > 6'd59) ? '0 : WriteData[5:0];
        wd_mm    = (WriteData[13:8]  > 6'd59) ? '0 : WriteData[13:8];
        wd_hh    = (WriteData[20:16] > 5'd23) ? '0 : WriteData[20:16];
    end

    // Prescaler advance and second tick; an EN 1->0 write freezes counting on its own edge.
    always_comb begin
        run  = en_q && !(wr_ctrl && !WriteData[0]);
        tick = run && (ps_q == PS_LAST);
        ps_d = ps_q;
        if (wr_time)
            ps_d = '0;
        else if (run)
            ps_d = tick ? '0 : ps_q + 24'd1;
    end

    // Time-of-day increment with carries through seconds, minutes and hours.
    always_comb begin
        nx_ss = ss_q;
        nx_mm = mm_q;
        nx_hh = hh_q;
        if (ss_q == 6'd59) begin
            nx_ss = '0;
            if (mm_q == 6'd59) begin
                nx_mm = '0;
                nx_hh = (hh_q == 5'd23) ? '0 : hh_q + 5'd1;
            end else begin
                nx_mm = mm_q + 6'd1;
            end
        end else begin
            nx_ss = ss_q + 6'd1;
        end
    end

    // Register next-state: a TIME write overrides a coincident tick, UPTIME still counts it.
    always_comb begin
        ss_d       = ss_q;
        mm_d       = mm_q;
        hh_d       = hh_q;
        al_ss_d    = al_ss_q;
        al_mm_d    = al_mm_q;
        al_hh_d    = al_hh_q;
        en_d       = en_q;
        alarm_en_d = alarm_en_q;
        uptime_d   = tick ? uptime_q + 32'd1 : uptime_q;
        if (wr_time) begin
            ss_d = wd_ss;
            mm_d = wd_mm;
            hh_d = wd_hh;
        end else if (tick) begin
            ss_d = nx_ss;
            mm_d = nx_mm;
            hh_d = nx_hh;
        end
        if (wr_alarm) begin
            al_ss_d = wd_ss;
            al_mm_d = wd_mm;
            al_hh_d = wd_hh;
        end
        if (wr_ctrl) begin
            en_d       = WriteData[0];
            alarm_en_d = WriteData[1];
        end
        match  = tick && !wr_time && alarm_en_q &&
                 ({nx_hh, nx_mm, nx_ss} == {al_hh_q, al_mm_q, al_ss_q});
        pend_d = pend_q;
        if (match)
            pend_d = 1'b1;
        else if (wr_ctrl && WriteData[2])
            pend_d = 1'b0;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q       <= '0;
            en_q       <= 1'b0;
            alarm_en_q <= 1'b0;
            pend_q     <= 1'b0;
            ss_q       <= '0;
            mm_q       <= '0;
            hh_q       <= '0;
            al_ss_q    <= '0;
            al_mm_q    <= '0;
            al_hh_q    <= '0;
            uptime_q   <= '0;
        end else begin
            ps_q       <= ps_d;
            en_q       <= en_d;
            alarm_en_q <= alarm_en_d;
            pend_q     <= pend_d;
            ss_q       <= ss_d;
            mm_q       <= mm_d;
            hh_q       <= hh_d;
            al_ss_q    <= al_ss_d;
            al_mm_q    <= al_mm_d;
            al_hh_q    <= al_hh_d;
            uptime_q   <= uptime_d;
        end
    end

    // Combinational read mux and registered-only interrupt.
    always_comb begin
        ReadData = '0;
        if (hit) begin
            case (ALUResult[3:2])
                2'd0:    ReadData = {29'b0, pend_q, alarm_en_q, en_q};
                2'd1:    ReadData = {11'b0, hh_q, 2'b0, mm_q, 2'b0, ss_q};
                2'd2:    ReadData = {11'b0, al_hh_q, 2'b0, al_mm_q, 2'b0, al_ss_q};
                default: ReadData = uptime_q;
            endcase
        end
        Sel = hit;
        Irq = pend_q & alarm_en_q;
    end

    assign unused_bits = ^{ALUResult[1:0], WriteData[31:21], WriteData[15:14], WriteData[7:6]};

endmodule

// File: tb/tb_rtc_mmio.sv
// tb_rtc_mmio: scoreboard bench for rtc_mmio with TICKS_PER_SEC=4, BASE_ADDR=0x1000.
module tb_rtc_mmio;

    localparam logic [31:0] A_CTRL  = 32'h1000;
    localparam logic [31:0] A_TIME  = 32'h1004;
    localparam logic [31:0] A_ALARM = 32'h1008;
    localparam logic [31:0] A_UP    = 32'h100C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Sel;
    logic        Irq;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    rtc_mmio #(.BASE_ADDR(32'h0000_1000), .TICKS_PER_SEC(4)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
        .WriteData(WriteData), .ReadData(ReadData), .Sel(Sel), .Irq(Irq)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a negedge: the write lands on the next posedge, returns at the following negedge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        ALUResult = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    // Push the expected word, let the combinational read settle, pop and compare.
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ALUResult = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        check(tag_q.pop_front(), ReadData, exp_q.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        MemWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_time", A_TIME, 32'h0);
        rd("rst_alarm", A_ALARM, 32'h0);
        rd("rst_up", A_UP, 32'h0);
        check("rst_irq", {31'b0, Irq}, 32'h0);

        // Basic counting
        wr(A_CTRL, 32'h1);
        cycles(3);
        rd("cnt_pre", A_TIME, 32'h0);
        cycles(1);
        rd("cnt_ss1", A_TIME, 32'h1);
        rd("cnt_up1", A_UP, 32'h1);
        cycles(4);
        rd("cnt_ss2", A_TIME, 32'h2);

        // Midnight rollover
        do_reset();
        wr(A_TIME, 32'h0017_3B3B);
        wr(A_CTRL, 32'h1);
        cycles(3);
        rd("roll_pre", A_TIME, 32'h0017_3B3B);
        cycles(1);
        rd("roll_time", A_TIME, 32'h0);
        rd("roll_up", A_UP, 32'h1);

        // Alarm match, clear, and interrupt gating
        do_reset();
        wr(A_ALARM, 32'h5);
        wr(A_CTRL, 32'h3);
        wr(A_TIME, 32'h4);
        cycles(3);
        check("al_irq_pre", {31'b0, Irq}, 32'h0);
        cycles(1);
        check("al_irq", {31'b0, Irq}, 32'h1);
        rd("al_ctrl", A_CTRL, 32'h7);
        wr(A_CTRL, 32'h7);
        check("al_clr_irq", {31'b0, Irq}, 32'h0);
        rd("al_clr_ctrl", A_CTRL, 32'h3);
        wr(A_CTRL, 32'h1);
        check("al_dis_irq", {31'b0, Irq}, 32'h0);
        rd("al_dis_ctrl", A_CTRL, 32'h1);

        // Range clamping, read-only UPTIME, decode miss
        do_reset();
        wr(A_TIME, 32'h0018_3C3C);
        rd("clamp_time", A_TIME, 32'h0);
        wr(A_ALARM, 32'h0017_3C3B);
        rd("clamp_alarm", A_ALARM, 32'h0017_003B);
        wr(A_UP, 32'h0000_FFFF);
        rd("up_ro", A_UP, 32'h0);
        check("sel_hit", {31'b0, Sel}, 32'h1);
        rd("miss_data", 32'h0000_2000, 32'h0);
        check("miss_sel", {31'b0, Sel}, 32'h0);

        // TIME write on the tick edge, then set-beats-clear on PEND
        do_reset();
        wr(A_CTRL, 32'h1);
        cycles(3);
        wr(A_TIME, 32'h0001_0203);
        rd("coll_time", A_TIME, 32'h0001_0203);
        rd("coll_up", A_UP, 32'h1);
        cycles(3);
        rd("coll_hold", A_TIME, 32'h0001_0203);
        cycles(1);
        rd("coll_next", A_TIME, 32'h0001_0204);
        rd("coll_up2", A_UP, 32'h2);
        wr(A_ALARM, 32'h0001_0205);
        wr(A_CTRL, 32'h3);
        cycles(1);
        wr(A_CTRL, 32'h7);
        rd("setclr_ctrl", A_CTRL, 32'h7);
        check("setclr_irq", {31'b0, Irq}, 32'h1);

        // Asynchronous reset between edges
        do_reset();
        wr(A_ALARM, 32'h0001_0204);
        wr(A_CTRL, 32'h3);
        wr(A_TIME, 32'h0001_0203);
        cycles(4);
        check("ar_irq_pre", {31'b0, Irq}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_irq", {31'b0, Irq}, 32'h0);
        rd("ar_ctrl", A_CTRL, 32'h0);
        rd("ar_time", A_TIME, 32'h0);
        rd("ar_alarm", A_ALARM, 32'h0);
        rd("ar_up", A_UP, 32'h0);
        @(negedge clk);
        wr(A_TIME, 32'h0001_0203);
        reset = 1'b0;
        rd("ar_wr_lost", A_TIME, 32'h0);
        cycles(6);
        rd("idle_time", A_TIME, 32'h0);
        rd("idle_up", A_UP, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
